// File: rtl/syn_global_pkg.sv
// Shared types and defaults for the syn local-bus blocks.
package syn_global_pkg;

  typedef enum logic [1:0] {
    LB_IDLE  = 2'd0,
    LB_ISSUE = 2'd1,
    LB_WAIT  = 2'd2,
    LB_RESP  = 2'd3
  } lb_mstr_state_e;

  localparam int LB_TIMEOUT_CYC_DEF = 256;
  localparam int LB_WAIT_CNT_W      = 16;
  localparam int LB_TMO_CNT_W       = 8;

endpackage

// File: rtl/syn_lb_mstr_if.sv
// Local-bus strobe/completion bundle; master drives strobes, slave drives completions.
interface syn_lb_intf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) ();

  logic              lb_rd_en;
  logic              lb_wr_en;
  logic [ADDR_W-1:0] lb_addr;
  logic [DATA_W-1:0] lb_wr_data;
  logic              lb_rd_valid;
  logic              lb_wr_valid;
  logic [DATA_W-1:0] lb_rd_data;

  modport master (
    output lb_rd_en, lb_wr_en, lb_addr, lb_wr_data,
    input  lb_rd_valid, lb_wr_valid, lb_rd_data
  );

  modport slave (
    input  lb_rd_en, lb_wr_en, lb_addr, lb_wr_data,
    output lb_rd_valid, lb_wr_valid, lb_rd_data
  );

endinterface

// File: rtl/syn_lb_mstr.sv
// Single-outstanding local-bus master: command in, one-cycle strobe out,
// wait for matching completion or timeout, hold response until accepted.
module syn_lb_mstr
  import syn_global_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = LB_TIMEOUT_CYC_DEF
) (
  input  logic                    clk_ir,
  input  logic                    rst_sync_l,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rd_n_wr,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [DATA_W-1:0]       cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [LB_TMO_CNT_W-1:0] timeout_cnt,
  syn_lb_intf.master              lb
);

  localparam logic [LB_WAIT_CNT_W-1:0] TMO_LIM = LB_WAIT_CNT_W'(TIMEOUT_CYC);

  lb_mstr_state_e           state, state_nxt;
  logic                     rd_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [LB_WAIT_CNT_W-1:0] wait_cnt, cnt_nxt;
  logic                     accept, busy, cmpl, tmo;
  logic                     rd_en, wr_en;

  assign lb.lb_rd_en   = rd_en;
  assign lb.lb_wr_en   = wr_en;
  assign lb.lb_addr    = addr_q;
  assign lb.lb_wr_data = wdata_q;

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) state <= LB_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    busy      = (state == LB_ISSUE) || (state == LB_WAIT);
    cnt_nxt   = wait_cnt + 1'b1;
    // only the valid matching the outstanding direction completes it
    cmpl      = busy && (rd_q ? lb.lb_rd_valid : lb.lb_wr_valid);
    // completion landing on the timeout cycle wins
    tmo       = busy && !cmpl && (cnt_nxt == TMO_LIM);
    unique case (state)
      LB_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = LB_ISSUE;
        end
      end
      LB_ISSUE: begin
        rd_en     = rd_q;
        wr_en     = !rd_q;
        state_nxt = (cmpl || tmo) ? LB_RESP : LB_WAIT;
      end
      LB_WAIT: begin
        if (cmpl || tmo) state_nxt = LB_RESP;
      end
      LB_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = LB_IDLE;
      end
      default: state_nxt = LB_IDLE;
    endcase
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      if (accept) begin
        rd_q     <= cmd_rd_n_wr;
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        wait_cnt <= '0;
      end else if (busy) begin
        wait_cnt <= cnt_nxt;
      end
      // response fields only move on completion/timeout, so stray valids can't touch them
      if (cmpl) begin
        rsp_rdata <= rd_q ? lb.lb_rd_data : '0;
        rsp_err   <= 1'b0;
      end else if (tmo) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_syn_lb_mstr.sv
// Directed bench for syn_lb_mstr; the bench plays the local-bus slave.
module tb_syn_lb_mstr;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int TMO = 16;

  logic          clk_ir = 1'b0;
  logic          rst_sync_l = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rd_n_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [7:0]    timeout_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_ir = ~clk_ir;

  syn_lb_intf #(.DATA_W(DW), .ADDR_W(AW)) lb_if ();

  syn_lb_mstr #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk_ir      (clk_ir),
    .rst_sync_l  (rst_sync_l),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rd_n_wr (cmd_rd_n_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .timeout_cnt (timeout_cnt),
    .lb          (lb_if)
  );

  task automatic tick;
    @(posedge clk_ir);
    #1;
  endtask

  // present a command in IDLE; returns in the strobe cycle (T+1)
  task automatic send_cmd(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid   = 1'b1;
    cmd_rd_n_wr = rd;
    cmd_addr    = a;
    cmd_wdata   = d;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic test_reset;
    lb_if.lb_rd_valid = 1'b0;
    lb_if.lb_wr_valid = 1'b0;
    lb_if.lb_rd_data  = '0;
    #1 rst_sync_l = 1'b0;
    #1;
    n_run++;
    if ({rsp_valid, rsp_err, lb_if.lb_rd_en, lb_if.lb_wr_en} !== 4'b0000 ||
        rsp_rdata !== 32'h0 || lb_if.lb_addr !== 12'h0 || lb_if.lb_wr_data !== 32'h0 ||
        timeout_cnt !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h tcnt=%0d want all 0",
               rsp_valid, rsp_err, lb_if.lb_rd_en, lb_if.lb_wr_en, rsp_rdata,
               lb_if.lb_addr, lb_if.lb_wr_data, timeout_cnt);
    end
    tick();
    tick();
    #3 rst_sync_l = 1'b1;
    tick();
    n_run++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write;
    int pulses = 0;
    send_cmd(1'b0, 12'h104, 32'hA5A5_0001);
    n_run++;
    if (lb_if.lb_wr_en !== 1'b1 || lb_if.lb_rd_en !== 1'b0 ||
        lb_if.lb_addr !== 12'h104 || lb_if.lb_wr_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL wr_strobe: wr=%b rd=%b addr=%h data=%h want 1/0/104/a5a50001",
               lb_if.lb_wr_en, lb_if.lb_rd_en, lb_if.lb_addr, lb_if.lb_wr_data);
    end
    tick();                                   // T+2
    pulses += int'(lb_if.lb_wr_en | lb_if.lb_rd_en);
    lb_if.lb_rd_valid = 1'b1;                 // wrong-direction valid
    lb_if.lb_rd_data  = 32'hFFFF_FFFF;
    tick();                                   // T+3
    pulses += int'(lb_if.lb_wr_en | lb_if.lb_rd_en);
    lb_if.lb_rd_valid = 1'b0;
    n_run++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ignore_rd_valid: rsp_valid=%b want 0", rsp_valid);
    end
    tick();                                   // T+4
    pulses += int'(lb_if.lb_wr_en | lb_if.lb_rd_en);
    lb_if.lb_wr_valid = 1'b1;
    tick();                                   // T+5 RESP
    lb_if.lb_wr_valid = 1'b0;
    n_run++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL wr_single_strobe: extra strobes=%0d want 0", pulses);
    end
    n_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || lb_if.lb_addr !== 12'h104) begin
      n_fail++;
      $display("FAIL wr_rsp: vld=%b err=%b rdata=%h addr=%h want 1/0/0/104",
               rsp_valid, rsp_err, rsp_rdata, lb_if.lb_addr);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_return_idle: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_fast;
    send_cmd(1'b1, 12'h210, 32'h0);
    n_run++;
    if (lb_if.lb_rd_en !== 1'b1 || lb_if.lb_wr_en !== 1'b0 || lb_if.lb_addr !== 12'h210) begin
      n_fail++;
      $display("FAIL rd_strobe: rd=%b wr=%b addr=%h want 1/0/210",
               lb_if.lb_rd_en, lb_if.lb_wr_en, lb_if.lb_addr);
    end
    lb_if.lb_rd_valid = 1'b1;
    lb_if.lb_rd_data  = 32'h1234_5678;
    tick();                                   // T+2
    lb_if.lb_rd_valid = 1'b0;
    n_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678 || lb_if.lb_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_fast_rsp: vld=%b err=%b rdata=%h rd_en=%b want 1/0/12345678/0",
               rsp_valid, rsp_err, rsp_rdata, lb_if.lb_rd_en);
    end
    lb_if.lb_rd_valid = 1'b1;                 // stray valids while in RESP
    lb_if.lb_wr_valid = 1'b1;
    lb_if.lb_rd_data  = 32'hDEAD_BEEF;
    tick();
    n_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rd_stray_resp: vld=%b rdata=%h want 1/12345678", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();                                   // stray valids in IDLE
    n_run++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rd_stray_idle: cmd_ready=%b vld=%b rdata=%h want 1/0/12345678",
               cmd_ready, rsp_valid, rsp_rdata);
    end
    lb_if.lb_rd_valid = 1'b0;
    lb_if.lb_wr_valid = 1'b0;
  endtask

  task automatic test_timeout;
    int early = 0;
    send_cmd(1'b1, 12'h3FC, 32'h0);           // T+1
    repeat (15) begin
      tick();
      early += int'(rsp_valid);
    end                                       // T+16
    n_run++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL tmo_not_early: rsp_valid cycles=%0d want 0", early);
    end
    tick();                                   // T+17
    n_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || timeout_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_rsp: vld=%b err=%b rdata=%h tcnt=%0d want 1/1/0/1",
               rsp_valid, rsp_err, rsp_rdata, timeout_cnt);
    end
    lb_if.lb_rd_valid = 1'b1;                 // late completion
    lb_if.lb_rd_data  = 32'h0000_CAFE;
    tick();
    n_run++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_late_valid: rdata=%h err=%b want 0/1", rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    lb_if.lb_rd_valid = 1'b0;
    n_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || timeout_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_after: vld=%b cmd_ready=%b tcnt=%0d want 0/1/1", rsp_valid, cmd_ready, timeout_cnt);
    end
  endtask

  task automatic test_tmo_edge;
    send_cmd(1'b1, 12'h3F8, 32'h0);           // T+1
    repeat (15) tick();                       // T+16, the timeout cycle
    n_run++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_waiting: rsp_valid=%b want 0", rsp_valid);
    end
    lb_if.lb_rd_valid = 1'b1;
    lb_if.lb_rd_data  = 32'h0BAD_F00D;
    tick();
    lb_if.lb_rd_valid = 1'b0;
    n_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D || timeout_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL edge_cmpl_wins: vld=%b err=%b rdata=%h tcnt=%0d want 1/0/0badf00d/1",
               rsp_valid, rsp_err, rsp_rdata, timeout_cnt);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int bad_stable = 0;
    int bad_ready  = 0;
    int strobes    = 0;
    send_cmd(1'b1, 12'h0AA, 32'h0);
    lb_if.lb_rd_valid = 1'b1;
    lb_if.lb_rd_data  = 32'h600D_CAFE;
    tick();                                   // RESP
    lb_if.lb_rd_valid = 1'b0;
    cmd_valid   = 1'b1;
    cmd_rd_n_wr = 1'b0;
    cmd_addr    = 12'h155;
    cmd_wdata   = 32'h1357_2468;
    repeat (10) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h600D_CAFE || rsp_err !== 1'b0) bad_stable++;
      if (cmd_ready !== 1'b0) bad_ready++;
      strobes += int'(lb_if.lb_rd_en | lb_if.lb_wr_en);
    end
    n_run++;
    if (bad_stable != 0) begin
      n_fail++;
      $display("FAIL bp_rsp_stable: unstable cycles=%0d want 0", bad_stable);
    end
    n_run++;
    if (bad_ready != 0 || strobes != 0) begin
      n_fail++;
      $display("FAIL bp_no_accept: cmd_ready cycles=%0d strobes=%0d want 0/0", bad_ready, strobes);
    end
    rsp_ready = 1'b1;
    tick();                                   // back in IDLE, command not taken in RESP
    rsp_ready = 1'b0;
    n_run++;
    if (cmd_ready !== 1'b1 || lb_if.lb_wr_en !== 1'b0 || lb_if.lb_addr !== 12'h0AA) begin
      n_fail++;
      $display("FAIL bp_no_turnaround: cmd_ready=%b wr=%b addr=%h want 1/0/0aa",
               cmd_ready, lb_if.lb_wr_en, lb_if.lb_addr);
    end
    tick();                                   // accepted in IDLE, now ISSUE
    cmd_valid = 1'b0;
    n_run++;
    if (lb_if.lb_wr_en !== 1'b1 || lb_if.lb_addr !== 12'h155 || lb_if.lb_wr_data !== 32'h1357_2468) begin
      n_fail++;
      $display("FAIL bp_next_cmd: wr=%b addr=%h data=%h want 1/155/13572468",
               lb_if.lb_wr_en, lb_if.lb_addr, lb_if.lb_wr_data);
    end
    lb_if.lb_wr_valid = 1'b1;
    tick();
    lb_if.lb_wr_valid = 1'b0;
    n_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_rsp: vld=%b rdata=%h err=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    send_cmd(1'b1, 12'h0C0, 32'h0);
    lb_if.lb_rd_valid = 1'b1;
    lb_if.lb_rd_data  = 32'h7777_8888;
    tick();
    lb_if.lb_rd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    send_cmd(1'b1, 12'h0C4, 32'h0);
    tick();
    tick();                                   // WAIT
    #1 rst_sync_l = 1'b0;
    #1;
    n_run++;
    if ({rsp_valid, rsp_err, lb_if.lb_rd_en, lb_if.lb_wr_en} !== 4'b0000 ||
        rsp_rdata !== 32'h0 || lb_if.lb_addr !== 12'h0 || lb_if.lb_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: vld=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h want all 0",
               rsp_valid, rsp_err, lb_if.lb_rd_en, lb_if.lb_wr_en, rsp_rdata,
               lb_if.lb_addr, lb_if.lb_wr_data);
    end
    n_run++;
    if (timeout_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_tcnt: tcnt=%0d want 0", timeout_cnt);
    end
    tick();
    #3 rst_sync_l = 1'b1;
    lb_if.lb_rd_valid = 1'b1;
    lb_if.lb_rd_data  = 32'h9999_9999;
    repeat (4) begin
      tick();
      seen += int'(rsp_valid);
    end
    lb_if.lb_rd_valid = 1'b0;
    n_run++;
    if (seen != 0 || cmd_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_abandon: rsp_valid cycles=%0d cmd_ready=%b rdata=%h want 0/1/0",
               seen, cmd_ready, rsp_rdata);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 300; i++) begin
      int k = 0;
      send_cmd(1'b1, 12'(i), 32'h0);
      while (rsp_valid !== 1'b1 && k < 40) begin
        tick();
        k++;
      end
      if (k >= 40) begin
        n_run++;
        n_fail++;
        $display("FAIL sat_wait: no response within 40 cycles on timeout %0d", i);
        break;
      end
      if (i == 253) begin
        n_run++;
        if (timeout_cnt !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_254: tcnt=%0d want 254", timeout_cnt);
        end
      end
      if (i == 254) begin
        n_run++;
        if (timeout_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL sat_255: tcnt=%0d want 255", timeout_cnt);
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    n_run++;
    if (timeout_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final: tcnt=%0d want 255", timeout_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_fast();
    test_timeout();
    test_tmo_edge();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
